// File: rtl/mem_stage_lsu_pkg.sv
// Shared constants for the memory-stage load/store unit: funct3 encodings,
// FSM state codes, default address base and an access-size helper.
package mem_stage_lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  localparam logic [63:0] LSU_ADDR_BASE = 64'h8000_0000;

  // Low address bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 3'b000;
      2'b01:   size_mask = 3'b001;
      2'b10:   size_mask = 3'b011;
      default: size_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_lane_fmt.sv
// Byte-lane formatting: store strobes/data shifted to the lane offset, and
// load data extracted from the lane and sign/zero extended to XLEN.
module lsu_lane_fmt
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [2:0]                  funct3,
  input  logic [$clog2(XLEN/8)-1:0]   off,
  input  logic [XLEN-1:0]             wdata,
  input  logic [XLEN-1:0]             rdata,
  output logic [XLEN/8-1:0]           wstrb_c,
  output logic [XLEN-1:0]             wdata_c,
  output logic [XLEN-1:0]             rdata_fmt_c
);

  localparam int unsigned STRB_W = XLEN / 8;

  logic [XLEN-1:0] shifted;

  assign wdata_c = wdata << {off, 3'b000};
  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    wstrb_c = '0;
    case (funct3[1:0])
      2'b00:   wstrb_c = STRB_W'(1)  << off;
      2'b01:   wstrb_c = STRB_W'(3)  << off;
      2'b10:   wstrb_c = STRB_W'(15) << off;
      default: wstrb_c = '1;
    endcase
  end

  always_comb begin
    rdata_fmt_c = '0;
    case (funct3)
      LB:      rdata_fmt_c = XLEN'($signed(shifted[7:0]));
      LH:      rdata_fmt_c = XLEN'($signed(shifted[15:0]));
      LW:      rdata_fmt_c = XLEN'($signed(shifted[31:0]));
      LD:      rdata_fmt_c = shifted;
      LBU:     rdata_fmt_c = XLEN'(shifted[7:0]);
      LHU:     rdata_fmt_c = XLEN'(shifted[15:0]);
      LWU:     rdata_fmt_c = XLEN'(shifted[31:0]);
      default: rdata_fmt_c = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit with valid/ready on EX and WB sides and a
// variable-latency memory port. Optional macro LSU_MISALIGN_EXC_EN turns
// misaligned accesses into exceptions instead of silently aligning them.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned ADDR_W    = 64,
  parameter logic [63:0] ADDR_BASE = LSU_ADDR_BASE,
  parameter int unsigned IDX_W     = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_pc,
  input  logic                in_is_load,
  input  logic                in_is_store,
  input  logic [2:0]          in_funct3,
  input  logic [XLEN-1:0]     in_alu_result,
  input  logic [XLEN-1:0]     in_wdata,
  input  logic [4:0]          in_rd,
  input  logic                in_rf_wen,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_wen,
  output logic [IDX_W-1:0]    mem_req_idx,
  output logic [XLEN-1:0]     mem_req_wdata,
  output logic [XLEN/8-1:0]   mem_req_wstrb,
  input  logic                mem_resp_valid,
  input  logic [XLEN-1:0]     mem_resp_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   out_pc,
  output logic [4:0]          out_rd,
  output logic                out_rf_wen,
  output logic [XLEN-1:0]     out_wb_data,
  output logic                out_exc
);

  localparam int unsigned STRB_W = XLEN / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);

  logic [1:0]          state, state_nxt;
  logic                hs, in_mem, illegal, misalign, direct, resp_take;
  logic [OFF_W-1:0]    in_off, align_mask, off_eff;
  logic [IDX_W-1:0]    req_idx;
  logic [2:0]          fmt_funct3;
  logic [OFF_W-1:0]    fmt_off;
  logic [STRB_W-1:0]   fmt_wstrb;
  logic [XLEN-1:0]     fmt_wdata, fmt_rdata;

  logic [ADDR_W-1:0]   op_pc;
  logic [4:0]          op_rd;
  logic                op_rf_wen, op_store;
  logic [2:0]          op_funct3;
  logic [OFF_W-1:0]    op_off;

  logic                out_valid_nxt, out_rf_wen_nxt, out_exc_nxt;
  logic [ADDR_W-1:0]   out_pc_nxt;
  logic [4:0]          out_rd_nxt;
  logic [XLEN-1:0]     out_wb_data_nxt;
  logic                req_valid_nxt, req_wen_nxt;
  logic [IDX_W-1:0]    req_idx_nxt;
  logic [XLEN-1:0]     req_wdata_nxt;
  logic [STRB_W-1:0]   req_wstrb_nxt;

  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
  assign hs       = in_valid && in_ready;
  assign in_mem   = in_is_load || in_is_store;
  assign illegal  = (XLEN == 32) && in_mem && ((in_funct3 == LD) || (in_funct3 == LWU));

  assign in_off     = in_alu_result[OFF_W-1:0];
  assign align_mask = OFF_W'(size_mask(in_funct3[1:0]));
  assign req_idx    = IDX_W'((ADDR_W'(in_alu_result) - ADDR_W'(ADDR_BASE)) >> OFF_W);

`ifdef LSU_MISALIGN_EXC_EN
  assign misalign = in_mem && (|(in_off & align_mask));
  assign off_eff  = in_off;
`else
  assign misalign = 1'b0;
  assign off_eff  = in_off & ~align_mask;
`endif

  // Ops that never touch memory complete straight from IDLE.
  assign direct    = !in_mem || illegal || misalign;
  assign resp_take = mem_resp_valid &&
                     ((state == ST_WAIT) || ((state == ST_REQ) && mem_req_ready));

  // IDLE formats the incoming store; afterwards the latched op formats the response.
  assign fmt_funct3 = (state == ST_IDLE) ? in_funct3 : op_funct3;
  assign fmt_off    = (state == ST_IDLE) ? off_eff   : op_off;

  lsu_lane_fmt #(.XLEN(XLEN)) u_lane_fmt (
    .funct3      (fmt_funct3),
    .off         (fmt_off),
    .wdata       (in_wdata),
    .rdata       (mem_resp_rdata),
    .wstrb_c     (fmt_wstrb),
    .wdata_c     (fmt_wdata),
    .rdata_fmt_c (fmt_rdata)
  );

  always_ff @(posedge clk) begin
    if (hs) begin
      op_pc     <= in_pc;
      op_rd     <= in_rd;
      op_rf_wen <= in_rf_wen;
      op_store  <= in_is_store;
      op_funct3 <= in_funct3;
      op_off    <= off_eff;
    end
  end

  always_comb begin
    state_nxt       = state;
    out_valid_nxt   = out_valid && !out_ready;
    out_pc_nxt      = out_pc;
    out_rd_nxt      = out_rd;
    out_rf_wen_nxt  = out_rf_wen;
    out_wb_data_nxt = out_wb_data;
    out_exc_nxt     = out_exc;
    req_valid_nxt   = mem_req_valid;
    req_wen_nxt     = mem_req_wen;
    req_idx_nxt     = mem_req_idx;
    req_wdata_nxt   = mem_req_wdata;
    req_wstrb_nxt   = mem_req_wstrb;

    case (state)
      ST_IDLE: begin
        if (hs && direct) begin
          out_valid_nxt   = 1'b1;
          out_pc_nxt      = in_pc;
          out_rd_nxt      = in_rd;
          out_rf_wen_nxt  = !in_mem && in_rf_wen;
          out_exc_nxt     = misalign && !illegal;
          out_wb_data_nxt = illegal ? '0 : in_alu_result;
          if (in_mem) state_nxt = ST_OUT;
        end else if (hs) begin
          req_valid_nxt = 1'b1;
          req_wen_nxt   = in_is_store;
          req_idx_nxt   = req_idx;
          req_wdata_nxt = in_is_store ? fmt_wdata : '0;
          req_wstrb_nxt = in_is_store ? fmt_wstrb : '0;
          state_nxt     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          req_valid_nxt = 1'b0;
          state_nxt     = mem_resp_valid ? ST_OUT : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid) state_nxt = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A response landing together with the request acceptance is taken here too.
    if (resp_take) begin
      out_valid_nxt   = 1'b1;
      out_pc_nxt      = op_pc;
      out_rd_nxt      = op_rd;
      out_rf_wen_nxt  = op_rf_wen && !op_store;
      out_wb_data_nxt = op_store ? '0 : fmt_rdata;
      out_exc_nxt     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_rd        <= '0;
      out_rf_wen    <= 1'b0;
      out_wb_data   <= '0;
      out_exc       <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_wen   <= 1'b0;
      mem_req_idx   <= '0;
      mem_req_wdata <= '0;
      mem_req_wstrb <= '0;
    end else begin
      state         <= state_nxt;
      out_valid     <= out_valid_nxt;
      out_pc        <= out_pc_nxt;
      out_rd        <= out_rd_nxt;
      out_rf_wen    <= out_rf_wen_nxt;
      out_wb_data   <= out_wb_data_nxt;
      out_exc       <= out_exc_nxt;
      mem_req_valid <= req_valid_nxt;
      mem_req_wen   <= req_wen_nxt;
      mem_req_idx   <= req_idx_nxt;
      mem_req_wdata <= req_wdata_nxt;
      mem_req_wstrb <= req_wstrb_nxt;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu (XLEN=64): directed ops push expected
// memory requests and writebacks; monitors compare whenever the DUT hands off.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_is_load, in_is_store, in_rf_wen;
  logic [63:0] in_pc, in_alu_result, in_wdata;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
  logic [31:0] mem_req_idx;
  logic [63:0] mem_req_wdata, mem_resp_rdata;
  logic [7:0]  mem_req_wstrb;
  logic        out_valid, out_ready, out_rf_wen, out_exc;
  logic [63:0] out_pc, out_wb_data;
  logic [4:0]  out_rd;

  typedef struct packed {
    logic [63:0] pc; logic [4:0] rd; logic rf_wen; logic [63:0] wb; logic exc;
  } out_t;
  typedef struct packed {
    logic [31:0] idx; logic wen; logic [63:0] wdata; logic [7:0] wstrb;
  } req_t;

  out_t exp_out[$];
  req_t exp_req[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_stage_lsu dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_is_load(in_is_load), .in_is_store(in_is_store), .in_funct3(in_funct3),
    .in_alu_result(in_alu_result), .in_wdata(in_wdata), .in_rd(in_rd), .in_rf_wen(in_rf_wen),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_idx(mem_req_idx), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd),
    .out_rf_wen(out_rf_wen), .out_wb_data(out_wb_data), .out_exc(out_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_out(input logic [63:0] pc, input logic [4:0] rd, input logic wen,
                          input logic [63:0] wb, input logic exc);
    out_t e;
    e.pc = pc; e.rd = rd; e.rf_wen = wen; e.wb = wb; e.exc = exc;
    exp_out.push_back(e);
  endtask

  task automatic push_req(input logic [31:0] idx, input logic wen,
                          input logic [63:0] wd, input logic [7:0] strb);
    req_t r;
    r.idx = idx; r.wen = wen; r.wdata = wd; r.wstrb = strb;
    exp_req.push_back(r);
  endtask

  // Presents one op and returns once it has been accepted (or timed out).
  task automatic issue(input logic [63:0] pc, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [63:0] alu, input logic [63:0] wd, input logic [4:0] rd,
                       input logic wen, output int waits);
    in_valid = 1'b1; in_pc = pc; in_is_load = ld; in_is_store = st; in_funct3 = f3;
    in_alu_result = alu; in_wdata = wd; in_rd = rd; in_rf_wen = wen;
    waits = 0;
    #1;
    while (!in_ready && waits < 50) begin
      step();
      waits++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles, required 1", waits);
    end
    step();
    in_valid = 1'b0;
  endtask

  // Memory side: accept after ready_delay cycles, respond same cycle or one later.
  task automatic serve(input int ready_delay, input bit same_cycle, input logic [63:0] rdata);
    repeat (ready_delay) step();
    mem_req_ready = 1'b1;
    if (same_cycle) begin
      mem_resp_valid = 1'b1; mem_resp_rdata = rdata;
    end
    step();
    mem_req_ready = 1'b0;
    if (!same_cycle) begin
      mem_resp_valid = 1'b1; mem_resp_rdata = rdata;
      step();
    end
    mem_resp_valid = 1'b0;
  endtask

  always @(negedge clk) begin : out_mon
    out_t e;
    if (!reset && out_valid && out_ready) begin
      if (exp_out.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL out_unexpected: got wb %h expected no output", out_wb_data);
      end else begin
        e = exp_out.pop_front();
        chk("out_wb_data", out_wb_data, e.wb);
        chk("out_meta", 64'({out_pc[31:0], 3'b0, out_rd, 3'b0, out_rf_wen, 3'b0, out_exc}),
            64'({e.pc[31:0], 3'b0, e.rd, 3'b0, e.rf_wen, 3'b0, e.exc}));
      end
    end
  end

  always @(negedge clk) begin : req_mon
    req_t r;
    if (!reset && mem_req_valid && mem_req_ready) begin
      if (exp_req.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL req_unexpected: got idx %h expected no request", mem_req_idx);
      end else begin
        r = exp_req.pop_front();
        chk("req_idx", 64'(mem_req_idx), 64'(r.idx));
        chk("req_wen", 64'(mem_req_wen), 64'(r.wen));
        if (r.wen) begin
          chk("req_wdata", mem_req_wdata, r.wdata);
          chk("req_wstrb", 64'(mem_req_wstrb), 64'(r.wstrb));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [2:0]  ld_f3   [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b110};
  logic [63:0] ld_addr [6] = '{64'h8000_0005, 64'h8000_0005, 64'h8000_0006,
                               64'h8000_0006, 64'h8000_0024, 64'h8000_0024};
  logic [63:0] ld_data [6] = '{64'h0000_8000_0000_0000, 64'h0000_8000_0000_0000,
                               64'h8001_0000_0000_0000, 64'h8001_0000_0000_0000,
                               64'h89AB_CDEF_0000_0000, 64'h89AB_CDEF_0000_0000};
  logic [63:0] ld_exp  [6] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_0080,
                               64'hFFFF_FFFF_FFFF_8001, 64'h0000_0000_0000_8001,
                               64'hFFFF_FFFF_89AB_CDEF, 64'h0000_0000_89AB_CDEF};
  logic [31:0] ld_idx  [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd4, 32'd4};

  logic        st_ld   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [2:0]  st_f3   [4] = '{3'b001, 3'b010, 3'b011, 3'b000};
  logic [63:0] st_addr [4] = '{64'h8000_0006, 64'h8000_000C, 64'h8000_0018, 64'h8000_0001};
  logic [63:0] st_wd   [4] = '{64'hBEEF, 64'h1234_5678, 64'h0102_0304_0506_0708, 64'h5A};
  logic [31:0] st_idx  [4] = '{32'd0, 32'd1, 32'd3, 32'd0};
  logic [7:0]  st_strb [4] = '{8'hC0, 8'hF0, 8'hFF, 8'h02};
  logic [63:0] st_wexp [4] = '{64'hBEEF_0000_0000_0000, 64'h1234_5678_0000_0000,
                               64'h0102_0304_0506_0708, 64'h5A00};

  initial begin
    int w;
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_is_load = 1'b0; in_is_store = 1'b0;
    in_funct3 = '0; in_alu_result = '0; in_wdata = '0; in_rd = '0; in_rf_wen = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0; out_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_wb_data", out_wb_data, 64'd0);

    // Back-to-back ALU ops stream at one per cycle.
    for (int i = 0; i < 3; i++) begin
      push_out(64'h1000 + 64'(4 * i), 5'(i + 1), 1'b1, 64'h1234 + 64'(i), 1'b0);
      issue(64'h1000 + 64'(4 * i), 1'b0, 1'b0, 3'b000, 64'h1234 + 64'(i), 64'd0, 5'(i + 1), 1'b1, w);
      chk("alu_stream_waits", 64'(w), 64'd0);
    end
    step(); step();

    // sb with a slow memory: request must hold steady, no writeback yet.
    push_req(32'd0, 1'b1, 64'hAB00_0000, 8'h08);
    push_out(64'h2000, 5'd3, 1'b0, 64'd0, 1'b0);
    issue(64'h2000, 1'b0, 1'b1, 3'b000, 64'h8000_0003, 64'hAB, 5'd3, 1'b1, w);
    repeat (3) begin
      chk("sb_hold_valid", 64'(mem_req_valid), 64'd1);
      chk("sb_hold_wdata", mem_req_wdata, 64'hAB00_0000);
      chk("sb_hold_wstrb", 64'(mem_req_wstrb), 64'h08);
      chk("sb_hold_no_out", 64'(out_valid), 64'd0);
      step();
    end
    serve(0, 1'b0, 64'd0);
    step();

    for (int i = 0; i < 6; i++) begin
      push_req(ld_idx[i], 1'b0, 64'd0, 8'h00);
      push_out(64'h3000 + 64'(4 * i), 5'd10, 1'b1, ld_exp[i], 1'b0);
      issue(64'h3000 + 64'(4 * i), 1'b1, 1'b0, ld_f3[i], ld_addr[i], 64'd0, 5'd10, 1'b1, w);
      serve(1, 1'b0, ld_data[i]);
      step();
    end

    for (int i = 0; i < 4; i++) begin
      push_req(st_idx[i], 1'b1, st_wexp[i], st_strb[i]);
      push_out(64'h4000 + 64'(4 * i), 5'd11, 1'b0, 64'd0, 1'b0);
      issue(64'h4000 + 64'(4 * i), st_ld[i], 1'b1, st_f3[i], st_addr[i], st_wd[i], 5'd11, 1'b1, w);
      serve(0, 1'b0, 64'd0);
      step();
    end

    // ld whose response coincides with request acceptance, WB stalled 2 cycles.
    out_ready = 1'b0;
    push_req(32'd2, 1'b0, 64'd0, 8'h00);
    push_out(64'h5000, 5'd12, 1'b1, 64'h1122_3344_5566_7788, 1'b0);
    issue(64'h5000, 1'b1, 1'b0, 3'b011, 64'h8000_0010, 64'd0, 5'd12, 1'b1, w);
    serve(0, 1'b1, 64'h1122_3344_5566_7788);
    repeat (2) begin
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_wb_data", out_wb_data, 64'h1122_3344_5566_7788);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("drain_in_ready", 64'(in_ready), 64'd1);

`ifdef LSU_MISALIGN_EXC_EN
    push_out(64'h6000, 5'd7, 1'b0, 64'h8000_0002, 1'b1);
    issue(64'h6000, 1'b1, 1'b0, 3'b010, 64'h8000_0002, 64'd0, 5'd7, 1'b1, w);
    chk("misalign_no_req", 64'(mem_req_valid), 64'd0);
    step();
`else
    push_req(32'd0, 1'b0, 64'd0, 8'h00);
    push_out(64'h6000, 5'd7, 1'b1, 64'h7654_3210, 1'b0);
    issue(64'h6000, 1'b1, 1'b0, 3'b010, 64'h8000_0002, 64'd0, 5'd7, 1'b1, w);
    serve(0, 1'b0, 64'h1111_1111_7654_3210);
    step();
`endif

    // Reset while the request is still pending.
    issue(64'h7000, 1'b1, 1'b0, 3'b010, 64'h8000_0000, 64'd0, 5'd8, 1'b1, w);
    chk("req_pending", 64'(mem_req_valid), 64'd1);
    reset = 1'b1;
    step();
    chk("rst_req_drop", 64'(mem_req_valid), 64'd0);
    reset = 1'b0;
    step();

    // Reset while waiting for the response.
    push_req(32'd0, 1'b0, 64'd0, 8'h00);
    issue(64'h7100, 1'b1, 1'b0, 3'b010, 64'h8000_0000, 64'd0, 5'd9, 1'b1, w);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("wait_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    step();
    chk("rst_wait_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_wait_out_valid", 64'(out_valid), 64'd0);
    chk("rst_wait_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;
    step(); step();

    chk("out_queue_left", 64'(exp_out.size()), 64'd0);
    chk("req_queue_left", 64'(exp_req.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
